wr_rd_sequencer: RTL

WR_RD_SEQUENCER -- requirements
Module: wr_rd_sequencer

---
 rtl/wr_rd_sequencer_if.sv | 28 ++
 rtl/wr_rd_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/wr_rd_sequencer_if.sv
// Request and memory-side signals of the write/readback sequencer; slave is the sequencer view.
// Backpressure: req_ready gates acceptance, memory side is strobe-driven with no stall.
interface wr_rd_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              pass;

    modport slave (
        input  req_valid, req_addr, req_data, rdata,
        output req_ready, wr, rd, addr, wdata, done, pass
    );

    modport master (
        output req_valid, req_addr, req_data, rdata,
        input  req_ready, wr, rd, addr, wdata, done, pass
    );
endinterface

// File: rtl/wr_rd_sequencer.sv
// Write one word, wait GAP cycles, read it back RD_LEN cycles, pulse done/pass; GAP+RD_LEN+2 cycles per request.
// Accepts only in IDLE (req_ready); optional err_cnt output under WR_RD_SEQUENCER_ERRCNT_EN.
module wr_rd_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int GAP    = 2,
    parameter int RD_LEN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    wr_rd_sequencer_if.slave      bus
`ifdef WR_RD_SEQUENCER_ERRCNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        GAP_W = 3'd2,
        READ  = 3'd3,
        CHECK = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Strobes are computed from the next state so the registered outputs line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_data;
                    wr_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d   = 4'(GAP - 2);
                state_d = GAP_W;
            end
            GAP_W: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'(RD_LEN - 1);
                    rd_d    = 1'b1;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    // Compare is registered so pass is valid alongside done in CHECK.
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    pass_d  = (bus.rdata == wdata_q);
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    rd_d  = 1'b1;
                end
            end
            CHECK: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.wr        = wr_q;
    assign bus.rd        = rd_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;

`ifdef WR_RD_SEQUENCER_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (done_q && !pass_q && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule
